// File: rtl/seq_csa_mult.sv
// rtl/seq_csa_mult.sv - multi-cycle carry-save multiplier with start/busy/done handshake
//
// Retires one partial-product row per clock into a 2*WIDTH-bit sum/carry
// accumulator, then resolves the product with a single carry-propagate add
// on the edge that enters DONE.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a multiply; accepted in IDLE or DONE
//   signed_mode  1 = two's-complement operands, 0 = unsigned; sampled with start
//   a, b         WIDTH-bit operands; sampled with start
//   busy         high while rows are being accumulated
//   done         one-cycle pulse when p has been updated
//   p            registered 2*WIDTH-bit product; held until the next done

module seq_csa_mult #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    sum_q;
    logic [PW-1:0]    carry_q;

    logic             accept;
    logic             last_row;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] pp_row;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    sum_n;
    logic [PW-1:0]    maj;
    logic [PW-1:0]    carry_n;
    logic [PW-1:0]    res;
    logic [PW-1:0]    p_next;

    assign accept   = start && (state != S_RUN);
    assign last_row = (cnt == CNT_W'(WIDTH - 1));

    // The magnitude of the most negative operand is 2^(WIDTH-1), which still
    // fits in WIDTH unsigned bits, so no extra bit is needed.
    assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

    always_comb begin
        pp_row  = mag_a & {WIDTH{mag_b[cnt]}};
        pp      = {{WIDTH{1'b0}}, pp_row} << cnt;
        // 3:2 compression: the carry word is shifted one place left; the bit
        // falling off the top is beyond 2*WIDTH and is dropped (modulo result).
        sum_n   = sum_q ^ carry_q ^ pp;
        maj     = (sum_q & carry_q) | (sum_q & pp) | (carry_q & pp);
        carry_n = {maj[PW-2:0], 1'b0};
        // The final row is folded in on the same edge that resolves the result.
        res     = sum_n + carry_n;
        p_next  = neg ? -res : res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            mag_a   <= '0;
            mag_b   <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            p       <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    sum_q   <= sum_n;
                    carry_q <= carry_n;
                    if (last_row) begin
                        p     <= p_next;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        mag_a   <= a_mag;
                        mag_b   <= b_mag;
                        neg     <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt     <= '0;
                        sum_q   <= '0;
                        carry_q <= '0;
                        state   <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule
